// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter used by the
// multi-cycle MIPS CPU and its program loader/debug port.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    localparam int MAX_LAT = 15;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin grant decision: a lone eligible port wins, and on a tie
// the port that was not granted last time wins.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic cpu_elig,
    input  logic ldr_elig,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    // Grant selection from eligibility and the previous winner
    always_comb begin
        grant_valid = cpu_elig | ldr_elig;
        grant_idx   = OWN_CPU;
        if (cpu_elig && ldr_elig) begin
            grant_idx = ~last_grant;
        end else if (ldr_elig) begin
            grant_idx = OWN_LDR;
        end else begin
            grant_idx = OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: grants the CPU or the loader, sequences a fixed-latency
// access to the unified memory and returns a one-cycle ready pulse to the owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              cpu_ready,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wd,
    output logic              ldr_ready,
    input  logic              cpu_hold,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy,
    output logic              owner
);

    // Out-of-range latencies are clamped so the counter never wraps
    localparam int LAT   = (MEM_LAT < 1) ? 1 : ((MEM_LAT > MAX_LAT) ? MAX_LAT : MEM_LAT);
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                owner_r;
    logic                last_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wd_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                grant_valid_s;
    logic                grant_idx_s;
    logic                cpu_elig_s;

    assign cpu_elig_s = cpu_req & ~cpu_hold;

    mem_arb_rr2 u_rr2 (
        .cpu_elig    (cpu_elig_s),
        .ldr_elig    (ldr_req),
        .last_grant  (last_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = ACCESS;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request latch, latency counter, read capture and last-grant tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= CNT_ZERO;
            owner_r <= OWN_CPU;
            last_r  <= OWN_LDR;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wd_r    <= {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r <= grant_idx_s;
                        cnt_r   <= CNT_ZERO;
                        we_r    <= (grant_idx_s == OWN_LDR) ? ldr_we   : cpu_we;
                        addr_r  <= (grant_idx_s == OWN_LDR) ? ldr_addr : cpu_addr;
                        wd_r    <= (grant_idx_s == OWN_LDR) ? ldr_wd   : cpu_wd;
                    end
                end
                ACCESS: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if ((cnt_r == CNT_LAST) && !we_r) begin
                        rdata_r <= mem_rd;
                    end
                end
                DONE: begin
                    last_r <= owner_r;
                end
                default: begin
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs decode only registered state; the strobe lasts the first access cycle
    assign mem_we    = (state_r == ACCESS) && we_r && (cnt_r == CNT_ZERO);
    assign mem_addr  = addr_r;
    assign mem_wd    = wd_r;
    assign rdata     = rdata_r;
    assign busy      = (state_r != IDLE);
    assign owner     = owner_r;
    assign cpu_ready = (state_r == DONE) && (owner_r == OWN_CPU);
    assign ldr_ready = (state_r == DONE) && (owner_r == OWN_LDR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share
// the requester inputs, each with its own behavioural memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we, cpu_hold;
    logic [31:0] cpu_addr, cpu_wd, ldr_addr, ldr_wd;

    logic        cpu_ready1, ldr_ready1, mem_we1, busy1, owner1;
    logic [31:0] rdata1, mem_addr1, mem_wd1, mem_rd1;
    logic        cpu_ready3, ldr_ready3, mem_we3, busy3, owner3;
    logic [31:0] rdata3, mem_addr3, mem_wd3, mem_rd3;

    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic        pre_en;
    logic [5:0]  pre_a;
    logic [31:0] pre_d;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_ready(cpu_ready1),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wd(ldr_wd), .ldr_ready(ldr_ready1),
        .cpu_hold(cpu_hold), .rdata(rdata1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wd(mem_wd1), .mem_rd(mem_rd1), .busy(busy1), .owner(owner1)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_ready(cpu_ready3),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wd(ldr_wd), .ldr_ready(ldr_ready3),
        .cpu_hold(cpu_hold), .rdata(rdata3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wd(mem_wd3), .mem_rd(mem_rd3), .busy(busy3), .owner(owner3)
    );

    // The address is stable for the whole access, so an asynchronous read meets any latency
    assign mem_rd1 = mem1[mem_addr1[7:2]];
    assign mem_rd3 = mem3[mem_addr3[7:2]];

    always @(posedge clk) begin
        if (mem_we1) mem1[mem_addr1[7:2]] <= mem_wd1;
        else if (pre_en) mem1[pre_a] <= pre_d;
        if (mem_we3) mem3[mem_addr3[7:2]] <= mem_wd3;
        else if (pre_en) mem3[pre_a] <= pre_d;
    end

    task automatic drive(input logic c, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic l, input logic lw, input logic [31:0] la, input logic [31:0] ld);
        cpu_req = c; cpu_we = cw; cpu_addr = ca; cpu_wd = cd;
        ldr_req = l; ldr_we = lw; ldr_addr = la; ldr_wd = ld;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_hold = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        pre_en = 1'b1; pre_a = 6'd4; pre_d = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({cpu_ready1, ldr_ready1, busy1, owner1, mem_we1} !== 5'b0) begin
            n_errors++; $display("FAIL reset_ctrl1 got %b want 00000", {cpu_ready1, ldr_ready1, busy1, owner1, mem_we1});
        end
        n_checks++;
        if ({mem_addr1, mem_wd1, rdata1} !== 96'h0) begin
            n_errors++; $display("FAIL reset_data1 got %h want 0", {mem_addr1, mem_wd1, rdata1});
        end
        n_checks++;
        if ({cpu_ready3, ldr_ready3, busy3, owner3, mem_we3} !== 5'b0) begin
            n_errors++; $display("FAIL reset_ctrl3 got %b want 00000", {cpu_ready3, ldr_ready3, busy3, owner3, mem_we3});
        end
        n_checks++;
        if ({mem_addr3, mem_wd3, rdata3} !== 96'h0) begin
            n_errors++; $display("FAIL reset_data3 got %h want 0", {mem_addr3, mem_wd3, rdata3});
        end
        pre_en = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if ({cpu_ready1, ldr_ready1} !== {1'(k == 2), 1'b0}) begin
                n_errors++; $display("FAIL cpu_read_ready1 k=%0d got %b", k, {cpu_ready1, ldr_ready1});
            end
            n_checks++;
            if ({cpu_ready3, ldr_ready3, busy3} !== {1'(k == 4), 1'b0, 1'(k <= 4)}) begin
                n_errors++; $display("FAIL cpu_read_ready3 k=%0d got %b", k, {cpu_ready3, ldr_ready3, busy3});
            end
            if (k == 2) begin
                n_checks++;
                if (rdata1 !== 32'hDEADBEEF) begin
                    n_errors++; $display("FAIL cpu_read_rdata1 got %h want deadbeef", rdata1);
                end
                cpu_req = 1'b0;
            end
            if (k == 4) begin
                n_checks++;
                if (rdata3 !== 32'hDEADBEEF) begin
                    n_errors++; $display("FAIL cpu_read_rdata3 got %h want deadbeef", rdata3);
                end
            end
        end
    endtask

    task automatic test_ldr_write();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (mem_we3 !== 1'(k == 1)) begin
                n_errors++; $display("FAIL ldr_write_we k=%0d got %b want %b", k, mem_we3, 1'(k == 1));
            end
            n_checks++;
            if ({cpu_ready3, ldr_ready3} !== {1'b0, 1'(k == 4)}) begin
                n_errors++; $display("FAIL ldr_write_ready k=%0d got %b", k, {cpu_ready3, ldr_ready3});
            end
            if (k == 1) begin
                n_checks++;
                if ({owner3, mem_addr3, mem_wd3} !== {1'b1, 32'h40, 32'h12345678}) begin
                    n_errors++; $display("FAIL ldr_write_bus got %h want 1_00000040_12345678", {owner3, mem_addr3, mem_wd3});
                end
            end
            if (k == 2) begin
                ldr_req = 1'b0; ldr_we = 1'b0;
            end
        end
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) cpu_req = 1'b0;
            if (k == 4) begin
                n_checks++;
                if ({cpu_ready3, rdata3} !== {1'b1, 32'h12345678}) begin
                    n_errors++; $display("FAIL ldr_readback got %h want 1_12345678", {cpu_ready3, rdata3});
                end
            end
        end
    endtask

    task automatic test_tie_fairness();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_checks++;
            if ({cpu_ready3, ldr_ready3} !== {1'(k == 4 || k == 14), 1'(k == 9 || k == 19)}) begin
                n_errors++; $display("FAIL tie_ready k=%0d got %b", k, {cpu_ready3, ldr_ready3});
            end
            if (k == 4 || k == 14) begin
                n_checks++;
                if (rdata3 !== 32'hDEADBEEF) begin
                    n_errors++; $display("FAIL tie_cpu_rdata k=%0d got %h want deadbeef", k, rdata3);
                end
            end
            if (k == 9 || k == 19) begin
                n_checks++;
                if (rdata3 !== 32'h12345678) begin
                    n_errors++; $display("FAIL tie_ldr_rdata k=%0d got %h want 12345678", k, rdata3);
                end
            end
            if (k == 19) begin
                cpu_req = 1'b0; ldr_req = 1'b0;
            end
        end
    endtask

    task automatic test_cpu_hold();
        cpu_hold = 1'b1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            n_checks++;
            if ({cpu_ready3, ldr_ready3} !== {1'(k == 14), 1'(k == 4 || k == 9)}) begin
                n_errors++; $display("FAIL hold_ready k=%0d got %b", k, {cpu_ready3, ldr_ready3});
            end
            if (k == 9)  cpu_hold = 1'b0;
            if (k == 11) cpu_hold = 1'b1;
            if (k == 14) begin
                cpu_req = 1'b0; ldr_req = 1'b0; cpu_hold = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if ({busy3, owner3} !== 2'b11) begin
                    n_errors++; $display("FAIL midrst_pre got %b want 11", {busy3, owner3});
                end
            end
            if (k == 2) begin
                reset = 1'b1; ldr_req = 1'b0;
                #1;
                n_checks++;
                if ({cpu_ready3, ldr_ready3, busy3, owner3, mem_we3} !== 5'b0) begin
                    n_errors++; $display("FAIL midrst_ctrl got %b want 00000", {cpu_ready3, ldr_ready3, busy3, owner3, mem_we3});
                end
                n_checks++;
                if ({mem_addr3, mem_wd3, rdata3} !== 96'h0) begin
                    n_errors++; $display("FAIL midrst_data got %h want 0", {mem_addr3, mem_wd3, rdata3});
                end
            end
            if (k >= 3) begin
                reset = 1'b0;
                n_checks++;
                if ({cpu_ready3, ldr_ready3, busy3} !== 3'b0) begin
                    n_errors++; $display("FAIL midrst_noready k=%0d got %b want 000", k, {cpu_ready3, ldr_ready3, busy3});
                end
            end
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (owner3 !== 1'b0) begin
                    n_errors++; $display("FAIL midrst_tie_owner got %b want 0", owner3);
                end
            end
            if (k == 2) begin
                cpu_req = 1'b0; ldr_req = 1'b0;
            end
            n_checks++;
            if ({cpu_ready3, ldr_ready3} !== {1'(k == 4), 1'b0}) begin
                n_errors++; $display("FAIL midrst_tie_ready k=%0d got %b", k, {cpu_ready3, ldr_ready3});
            end
        end
    endtask

    task automatic test_input_change();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                n_checks++;
                if (mem_addr3 !== 32'h40) begin
                    n_errors++; $display("FAIL chg_addr k=%0d got %h want 00000040", k, mem_addr3);
                end
            end
            if (k == 1) cpu_addr = 32'h10;
            if (k == 2) cpu_req = 1'b0;
            if (k == 4) begin
                n_checks++;
                if ({cpu_ready3, rdata3} !== {1'b1, 32'h12345678}) begin
                    n_errors++; $display("FAIL chg_rdata got %h want 1_12345678", {cpu_ready3, rdata3});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_tie_fairness();
        test_cpu_hold();
        test_reset_mid_access();
        test_input_change();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
